// File: rtl/swizzle_c2d_sched.sv
// CRAM-to-DRAM read scheduler: issues sequential CRAM reads under dst_ready
// back-pressure and steers the read data into ping/pong buffers.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; abort ignored
// S_READ  | one CRAM read per cycle while dst_ready, until remaining hits 0
// S_DRAIN | last read word is returning from CRAM (data_valid in flight)
// S_DONE  | job complete; done pulses on the following cycle
module swizzle_c2d_sched #(
    parameter int RAM_AWIDTH      = 9,
    parameter int LEN_WIDTH       = 10,
    parameter int COUNT_TO_SWITCH = 40
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [RAM_AWIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    input  logic                  abort,
    input  logic                  dst_ready,
    output logic [RAM_AWIDTH-1:0] ram_addr,
    output logic                  ram_re,
    output logic                  data_valid,
    output logic                  buf_sel,
    output logic                  buf_switch,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (COUNT_TO_SWITCH > 1) ? $clog2(COUNT_TO_SWITCH) : 1;
    localparam logic [CW-1:0] WC_LAST = CW'(COUNT_TO_SWITCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [RAM_AWIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic                  data_valid_q, data_valid_d;
    logic                  buf_sel_q, buf_sel_d;
    logic                  buf_switch_q, buf_switch_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        remaining_d  = remaining_q;
        word_cnt_d   = word_cnt_q;
        buf_sel_d    = buf_sel_q;
        buf_switch_d = 1'b0;
        done_d       = 1'b0;
        ram_re       = (state_q == S_READ) && dst_ready && !abort;
        data_valid_d = ram_re;

        // Buffer accounting follows returned data, so in-flight words still count.
        if (data_valid_q) begin
            if (word_cnt_q == WC_LAST) begin
                word_cnt_d   = '0;
                buf_sel_d    = ~buf_sel_q;
                buf_switch_d = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (num_words != '0) begin
                        state_d      = S_READ;
                        ram_addr_d   = start_addr;
                        remaining_d  = num_words;
                        word_cnt_d   = '0;
                        buf_sel_d    = 1'b0;
                        buf_switch_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dst_ready) begin
                    ram_addr_d  = ram_addr_q + RAM_AWIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = abort ? S_IDLE : S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = !abort;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            ram_addr_q   <= '0;
            remaining_q  <= '0;
            word_cnt_q   <= '0;
            data_valid_q <= 1'b0;
            buf_sel_q    <= 1'b0;
            buf_switch_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            remaining_q  <= remaining_d;
            word_cnt_q   <= word_cnt_d;
            data_valid_q <= data_valid_d;
            buf_sel_q    <= buf_sel_d;
            buf_switch_q <= buf_switch_d;
            done_q       <= done_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign data_valid = data_valid_q;
    assign buf_sel    = buf_sel_q;
    assign buf_switch = buf_switch_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_swizzle_c2d_sched.sv
// Bench for swizzle_c2d_sched: table of directed jobs, hand-written corner
// sequences and randomized jobs checked against a transaction-level model.
module tb_swizzle_c2d_sched;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic [8:0] start_addr = '0;
    logic [9:0] num_words = '0;
    logic       abort = 1'b0;
    logic       dst_ready = 1'b0;
    logic [8:0] ram_addr;
    logic       ram_re, data_valid, buf_sel, buf_switch, busy, done;

    swizzle_c2d_sched dut (
        .clk(clk), .resetn(resetn), .start(start), .start_addr(start_addr),
        .num_words(num_words), .abort(abort), .dst_ready(dst_ready),
        .ram_addr(ram_addr), .ram_re(ram_re), .data_valid(data_valid),
        .buf_sel(buf_sel), .buf_switch(buf_switch), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model / observation state
    logic [8:0]  m_addr = '0;
    logic [8:0]  last_addr = '0;
    logic [8:0]  stall_addr = '0;
    bit          m_sel = 0, m_pend = 0, prev_re = 0;
    int          m_cnt = 0;
    int          reads, dvs, dones, nsw, job_err, cyc;
    logic [63:0] re_mask, dv_mask, done_mask, busy_mask;

    typedef struct {
        logic [8:0]  sa;
        logic [9:0]  nw;
        int          exp_reads;
        logic [8:0]  exp_last;
        int          exp_sw;
        bit          exp_sel;
        bit          chk_mask;
        logic [63:0] exp_re, exp_dv, exp_done, exp_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle of inputs, observe at negedge.
    task automatic step(input bit st, input logic [8:0] sa, input logic [9:0] nw,
                        input bit rdy, input bit ab, input bit real_start);
        start = st; start_addr = sa; num_words = nw; dst_ready = rdy; abort = ab;
        @(negedge clk);
        if (ram_re && (!rdy || ab)) job_err++;
        if (data_valid !== prev_re) job_err++;
        if (buf_switch !== m_pend) job_err++;
        if (buf_sel !== m_sel) job_err++;
        if (ram_re) begin
            if (ram_addr !== m_addr) job_err++;
            last_addr = ram_addr;
            m_addr = m_addr + 9'd1;
            reads++;
        end
        if (!rdy) stall_addr = ram_addr;
        if (done) dones++;
        if (buf_switch) nsw++;
        if (cyc < 64) begin
            re_mask[cyc] = ram_re; dv_mask[cyc] = data_valid;
            done_mask[cyc] = done; busy_mask[cyc] = busy;
        end
        prev_re = ram_re;
        m_pend = 0;
        if (data_valid) begin
            dvs++;
            m_cnt++;
            if (m_cnt == 40) begin
                m_cnt = 0; m_sel = ~m_sel; m_pend = 1;
            end
        end
        if (real_start && !ab && nw != 0) begin
            m_addr = sa; m_cnt = 0; m_sel = 0; m_pend = 0;
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        reads = 0; dvs = 0; dones = 0; nsw = 0; job_err = 0; cyc = 0;
        re_mask = '0; dv_mask = '0; done_mask = '0; busy_mask = '0;
        last_addr = '0;
    endtask

    task automatic run_job(input logic [8:0] sa, input logic [9:0] nw,
                           input int stall_after, input int stall_len,
                           input int abort_read, input int abort_cyc, input bit rnd);
        int  stall_cnt = 0;
        int  tail = -1;
        bit  aborted = 0;
        bit  rdy, ab, st;
        clear_obs();
        step(1'b1, sa, nw, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            if (reads == stall_after && stall_cnt < stall_len) begin
                rdy = 0; stall_cnt++;
            end else begin
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            ab = 0;
            if (!aborted && busy &&
                ((abort_read >= 0 && reads == abort_read) || (abort_cyc >= 0 && cyc == abort_cyc))) begin
                ab = 1; aborted = 1;
            end
            st = rnd && busy && ($urandom_range(0, 7) == 0);
            step(st, 9'($urandom), 10'($urandom), rdy, ab, 1'b0);
            if (tail > 0) begin
                tail--;
                if (tail == 0) break;
            end else if (dones > 0 || aborted) begin
                tail = 3;
            end
        end
        if (tail != 0) check("job_timeout", tail, 0);
    endtask

    initial begin
        vecs[0] = '{9'h010, 10'd3,    3,    9'h012, 0,  0, 1, 64'hE, 64'h1C, 64'h40, 64'h3E};
        vecs[1] = '{9'h000, 10'd0,    0,    9'h000, 0,  0, 1, 64'h0, 64'h0,  64'h4,  64'h2};
        vecs[2] = '{9'h1FE, 10'd4,    4,    9'h001, 0,  0, 0, 0, 0, 0, 0};
        vecs[3] = '{9'h000, 10'd40,   40,   9'h027, 1,  1, 0, 0, 0, 0, 0};
        vecs[4] = '{9'h100, 10'd90,   90,   9'h159, 2,  0, 0, 0, 0, 0, 0};
        vecs[5] = '{9'h1F0, 10'd41,   41,   9'h018, 1,  1, 0, 0, 0, 0, 0};
        vecs[6] = '{9'h005, 10'd1,    1,    9'h005, 0,  0, 0, 0, 0, 0, 0};
        vecs[7] = '{9'h003, 10'd1023, 1023, 9'h001, 25, 1, 0, 0, 0, 0, 0};
        vecs[8] = '{9'h077, 10'd0,    0,    9'h000, 0,  1, 0, 0, 0, 0, 0};

        // power-on reset, asserted between edges
        #1 resetn = 1'b0;
        #1;
        check("reset_outputs", {ram_addr, ram_re, data_valid, buf_sel, buf_switch, busy, done}, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i].sa, vecs[i].nw, -1, 0, -1, -1, 1'b0);
            check($sformatf("vec%0d_reads", i), reads, vecs[i].exp_reads);
            check($sformatf("vec%0d_dvalid", i), dvs, vecs[i].exp_reads);
            check($sformatf("vec%0d_last_addr", i), last_addr, vecs[i].exp_last);
            check($sformatf("vec%0d_switches", i), nsw, vecs[i].exp_sw);
            check($sformatf("vec%0d_buf_sel", i), buf_sel, vecs[i].exp_sel);
            check($sformatf("vec%0d_done", i), dones, 1);
            check($sformatf("vec%0d_protocol", i), job_err, 0);
            if (vecs[i].chk_mask) begin
                check($sformatf("vec%0d_re_cycles", i), re_mask, vecs[i].exp_re);
                check($sformatf("vec%0d_dv_cycles", i), dv_mask, vecs[i].exp_dv);
                check($sformatf("vec%0d_done_cycle", i), done_mask, vecs[i].exp_done);
                check($sformatf("vec%0d_busy_cycles", i), busy_mask, vecs[i].exp_busy);
            end
        end

        // stall of 3 cycles after the 2nd read
        run_job(9'h020, 10'd5, 2, 3, -1, -1, 1'b0);
        check("stall_reads", reads, 5);
        check("stall_dvalid", dvs, 5);
        check("stall_addr_hold", stall_addr, 9'h022);
        check("stall_protocol", job_err, 0);
        check("stall_re_cycles", re_mask, 64'h1C6);

        // abort during the 3rd word of 10
        run_job(9'h040, 10'd10, -1, 0, 2, -1, 1'b0);
        check("abort_read_reads", reads, 2);
        check("abort_read_dvalid", dvs, 2);
        check("abort_read_done", dones, 0);
        check("abort_read_busy", busy_mask, 64'hE);
        check("abort_read_protocol", job_err, 0);

        // abort in DRAIN, then in DONE, for a one-word job
        run_job(9'h050, 10'd1, -1, 0, -1, 2, 1'b0);
        check("abort_drain_done", dones, 0);
        check("abort_drain_dvalid", dvs, 1);
        check("abort_drain_busy", busy_mask, 64'h6);
        run_job(9'h050, 10'd1, -1, 0, -1, 3, 1'b0);
        check("abort_done_done", dones, 0);
        check("abort_done_busy", busy_mask, 64'hE);
        check("abort_done_protocol", job_err, 0);

        // abort alone in IDLE, then abort together with start
        clear_obs();
        step(1'b0, 9'h0, 10'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 9'h060, 10'd5, 1'b1, 1'b1, 1'b1);
        step(1'b0, 9'h0, 10'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 9'h0, 10'd0, 1'b1, 1'b0, 1'b0);
        check("abort_idle_busy", busy_mask, 64'h0);
        check("abort_idle_reads", reads, 0);
        check("abort_idle_done", dones, 0);

        // randomized jobs with stalls, ignored starts and occasional aborts
        for (int j = 0; j < 30; j++) begin
            logic [8:0] sa;
            logic [9:0] nw;
            int ar, exp_reads;
            sa = 9'($urandom);
            nw = (j == 0) ? 10'd300 : 10'($urandom_range(0, 130));
            ar = -1;
            if (nw != 0 && $urandom_range(0, 3) == 0) ar = $urandom_range(0, int'(nw) - 1);
            exp_reads = (ar >= 0) ? ar : int'(nw);
            run_job(sa, nw, -1, 0, ar, -1, 1'b1);
            check($sformatf("rand%0d_reads", j), reads, exp_reads);
            check($sformatf("rand%0d_dvalid", j), dvs, exp_reads);
            check($sformatf("rand%0d_done", j), dones, (ar >= 0) ? 0 : 1);
            check($sformatf("rand%0d_protocol", j), job_err, 0);
        end

        // reset asserted mid-job, between clock edges
        clear_obs();
        step(1'b1, 9'h080, 10'd100, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 9'h0, 10'd0, 1'b1, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("midjob_reset_outputs", {ram_addr, ram_re, data_valid, buf_sel, buf_switch, busy, done}, 0);
        @(negedge clk);
        resetn = 1'b1;
        prev_re = 0; m_pend = 0; m_sel = 0; m_cnt = 0;
        @(posedge clk); #1;
        clear_obs();
        repeat (4) step(1'b0, 9'h0, 10'd0, 1'b1, 1'b0, 1'b0);
        check("post_reset_idle", busy_mask, 64'h0);
        check("post_reset_reads", reads, 0);
        check("post_reset_protocol", job_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
